// File: rtl/exu_axi_rd_arbiter.sv
// exu_axi_rd_arbiter
// -----------------------------------------------------------------------------
// Shares the core's single AXI read port (AR + R) between two masters:
//   master 0 = IFU instruction fetch, master 1 = EXU LSU load path.
// Only one transaction is in flight at a time. A master owns the channel from
// arbitration until the R beat that carries rlast.
//
// Configuration macro:
//   EXU_ARB_RR_EN  defined   -> round-robin on a conflict (master != last_grant)
//                  undefined -> fixed priority, master 1 over master 0
//
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   m0_* / m1_*             master-side AR request and R response
//   s_*                     slave-side AR request and R response
//   busy                    1 while in ADDR or DATA phase
//   grant                   index of the master that owns the channel
//   err_len                 one-cycle pulse when the rlast position disagrees
//                           with the accepted burst length
//   dbg_state               FSM state (0 IDLE, 1 ADDR, 2 DATA)
//   dbg_last_grant          master that completed the previous transaction
//
// Handshake rule (both AR and R channels): a transfer happens on a rising
// clock edge where valid and ready are both 1. valid never depends on ready.
// The arbiter only wires the owning master's valid/ready through; the other
// master sees valid=0 / ready=0 until it is granted.
// -----------------------------------------------------------------------------
module exu_axi_rd_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          m0_arvalid,
    output logic          m0_arready,
    input  logic [AW-1:0] m0_araddr,
    input  logic [LW-1:0] m0_arlen,
    input  logic [2:0]    m0_arsize,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rresp,
    output logic          m0_rlast,

    input  logic          m1_arvalid,
    output logic          m1_arready,
    input  logic [AW-1:0] m1_araddr,
    input  logic [LW-1:0] m1_arlen,
    input  logic [2:0]    m1_arsize,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rresp,
    output logic          m1_rlast,

    output logic          s_arvalid,
    input  logic          s_arready,
    output logic [AW-1:0] s_araddr,
    output logic [LW-1:0] s_arlen,
    output logic [2:0]    s_arsize,
    input  logic          s_rvalid,
    output logic          s_rready,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_rresp,
    input  logic          s_rlast,

    output logic          busy,
    output logic          grant,
    output logic          err_len,
    output logic [1:0]    dbg_state,
    output logic          dbg_last_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [LW-1:0] len_r;
    logic [LW-1:0] beat_cnt;

    logic in_addr;
    logic in_data;
    logic win;
    logic r_hs;

    // Phase qualifiers are forced low while reset is asserted so every
    // valid/ready output drops immediately, even in the reset cycle itself.
    assign in_addr = !reset && (state == ST_ADDR);
    assign in_data = !reset && (state == ST_DATA);

    // Arbitration winner, only consumed in IDLE.
    always_comb begin
`ifdef EXU_ARB_RR_EN
        if (m0_arvalid && m1_arvalid)
            win = ~last_grant;
        else
            win = m1_arvalid;
`else
        win = m1_arvalid;
`endif
    end

    // AR channel: forward the owning master only during ADDR.
    assign s_arvalid  = in_addr && (grant ? m1_arvalid : m0_arvalid);
    assign s_araddr   = grant ? m1_araddr : m0_araddr;
    assign s_arlen    = grant ? m1_arlen  : m0_arlen;
    assign s_arsize   = grant ? m1_arsize : m0_arsize;
    assign m0_arready = in_addr && !grant && s_arready;
    assign m1_arready = in_addr &&  grant && s_arready;

    // R channel: payload is broadcast, only valid is steered.
    assign s_rready  = in_data && (grant ? m1_rready : m0_rready);
    assign m0_rvalid = in_data && !grant && s_rvalid;
    assign m1_rvalid = in_data &&  grant && s_rvalid;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;

    assign r_hs = s_rvalid && s_rready;

    assign busy           = in_addr || in_data;
    assign dbg_state      = state;
    assign dbg_last_grant = last_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            len_r      <= '0;
            beat_cnt   <= '0;
            err_len    <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // One bubble cycle: the winner is latched here and only
                    // forwarded to the slave from the next cycle on.
                    if (m0_arvalid || m1_arvalid) begin
                        grant <= win;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_arvalid && s_arready) begin
                        len_r    <= grant ? m1_arlen : m0_arlen;
                        beat_cnt <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + LW'(1);
                        // beat_cnt is the index of the current beat; rlast must
                        // coincide with index len_r. The FSM itself trusts rlast.
                        err_len  <= s_rlast ? (beat_cnt != len_r)
                                            : (beat_cnt == len_r);
                        if (s_rlast) begin
                            state      <= ST_IDLE;
                            last_grant <= grant;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
